fpadd_issue_ctrl: RTL and testbench

//  Sequential front end for the combinational single-precision adder (fpadder).
//  - Accepts operand pairs over a valid/ready handshake and buffers them in a small queue.
//  - Screens IEEE-754 special cases, then drives the adder's src1/src2 from registers.
//  - Captures the adder's out, or a bypass result, and returns it over a valid/ready handshake.

---
 rtl/fpadd_pkg.sv | 34 +++
 rtl/fpadd_opq.sv | 70 +++++++
 rtl/fpadd_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_fpadd_issue_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// ============================================================================
//  Module      : fpadd_pkg
//  Description : IEEE-754 single-precision classes, constants and classifier
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fpadd_pkg;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_DENORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    function automatic fp_class_e fp_classify(input logic [31:0] x);
        fp_class_e c;
        if (x[30:23] == FP_EXP_MAX)
            c = (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else if (x[30:23] == 8'h00)
            c = (x[22:0] != 23'd0) ? CLS_DENORM : CLS_ZERO;
        else
            c = CLS_NORM;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpadd_opq.sv
// ============================================================================
//  Module      : fpadd_opq
//  Description : DEPTH-entry FIFO holding {A, B} operand pairs
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpadd_opq #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage carries no reset: contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop_ok)
                r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpadd_issue_ctrl.sv
// ============================================================================
//  Module      : fpadd_issue_ctrl
//  Description : Queued issue/return front end for a combinational FP adder;
//                FPADD_FLUSH_DENORM_EN enables denormal flush-to-zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpadd_issue_ctrl
    import fpadd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic [31:0] add_src1,
    output logic [31:0] add_src2,
    input  logic [31:0] add_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_flags,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_src1, r_src2, r_byp, r_res_data;
    logic          r_byp_en, r_res_valid;
    logic [2:0]    r_res_flags;

    logic          w_full, w_empty, w_load, w_byp;
    logic [CW-1:0] w_count;
    logic [63:0]   w_head;
    logic [31:0]   w_a, w_b, w_byp_val, w_res;
    logic [2:0]    w_flags;
    fp_class_e     w_cls_a, w_cls_b;

    assign in_ready = !w_full;
    assign w_load   = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && res_ready));

    fpadd_opq #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_opq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (in_valid && in_ready),
        .i_wr_data ({in_a, in_b ^ {in_sub, 31'b0}}),
        .i_pop     (w_load),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_comb begin
        w_a = w_head[63:32];
        w_b = w_head[31:0];
`ifdef FPADD_FLUSH_DENORM_EN
        if (fp_classify(w_a) == CLS_DENORM) w_a = {w_a[31], 31'b0};
        if (fp_classify(w_b) == CLS_DENORM) w_b = {w_b[31], 31'b0};
`endif
        w_cls_a   = fp_classify(w_a);
        w_cls_b   = fp_classify(w_b);
        w_byp     = 1'b1;
        w_byp_val = FP_QNAN;
        if ((w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN))
            w_byp_val = FP_QNAN;
        else if ((w_cls_a == CLS_INF) && (w_cls_b == CLS_INF) && (w_a[31] != w_b[31]))
            w_byp_val = FP_QNAN;
        else if (w_cls_a == CLS_INF)
            w_byp_val = w_a;
        else if (w_cls_b == CLS_INF)
            w_byp_val = w_b;
        else begin
            w_byp     = 1'b0;
            w_byp_val = '0;
        end
    end

    always_comb begin
        w_res = r_byp_en ? r_byp : add_out;
`ifdef FPADD_FLUSH_DENORM_EN
        if (w_res[30:23] == 8'h00) w_res = {w_res[31], 31'b0};
`endif
        w_flags = {(w_res[30:23] == FP_EXP_MAX) && (w_res[22:0] != 23'd0),
                   (w_res[30:23] == FP_EXP_MAX) && (w_res[22:0] == 23'd0),
                   (w_res[30:0] == 31'd0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_src1      <= '0;
            r_src2      <= '0;
            r_byp       <= '0;
            r_byp_en    <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_valid <= 1'b0;
        end else begin
            // Operands are always loaded so the adder sees stable inputs, even on bypass.
            if (w_load) begin
                r_src1   <= w_a;
                r_src2   <= w_b;
                r_byp    <= w_byp_val;
                r_byp_en <= w_byp;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_load)
                        r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    r_res_data  <= w_res;
                    r_res_flags <= w_flags;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Valid drops on the handshake so a result is never offered twice.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_load ? ST_EVAL : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign add_src1  = r_src1;
    assign add_src2  = r_src2;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;
    assign busy      = (r_state != ST_IDLE) || (w_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_fpadd_issue_ctrl.sv
// ============================================================================
//  Module      : tb_fpadd_issue_ctrl
//  Description : Scoreboard bench for fpadd_issue_ctrl with a table-driven adder
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpadd_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sub = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready, res_valid, busy;
    logic [31:0] add_src1, add_src2, add_out, res_data;
    logic [2:0]  res_flags;

    int total = 0;
    int bad   = 0;
    logic [34:0] sb[$];

    always #5 clk = ~clk;

    fpadd_issue_ctrl #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .add_src1  (add_src1),
        .add_src2  (add_src2),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags),
        .busy      (busy)
    );

    // Stand-in adder: hand-computed sums for the operand pairs used below.
    function automatic logic [31:0] adder_model(input logic [31:0] s1, input logic [31:0] s2);
        case ({s1, s2})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40000000, 32'h40400000}: return 32'h40A00000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h00000001, 32'h00000001}: return 32'h00000002;
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    assign add_out = adder_model(add_src1, add_src2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=done", name);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_d, input logic [2:0] exp_f);
        bit ok = 1'b0;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (in_ready) begin
                sb.push_back({exp_d, exp_f});
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sub   = 1'b0;
        if (!ok) fail_timeout("send");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || res_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy || res_valid) fail_timeout("wait_idle");
    endtask

    always @(negedge clk) begin
        logic [34:0] e;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: actual=%h required=none", res_data);
            end else begin
                e = sb.pop_front();
                check("res_data", res_data, e[34:3]);
                check("res_flags", 32'(res_flags), 32'(e[2:0]));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_src1",      add_src1,       32'd0);
        check("rst_src2",      add_src2,       32'd0);
        check("rst_res_data",  res_data,       32'd0);
        check("rst_res_flags", 32'(res_flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b1;

        // Latency: valid two edges after the accepting edge
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        check("lat_e0_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e1_valid", 32'(res_valid), 32'd0);
        check("issue_src1", add_src1, 32'h3F800000);
        check("issue_src2", add_src2, 32'h40000000);
        @(posedge clk); #1;
        check("lat_e2_valid", 32'(res_valid), 32'd1);
        wait_idle();

        // Subtraction flips B's sign at enqueue
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b001);
        @(posedge clk); #1;
        check("sub_src2", add_src2, 32'hBF800000);
        wait_idle();

        // Special-case bypasses
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        wait_idle();
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b010);
        wait_idle();
        check("byp_src1", add_src1, 32'h7F800000);
        check("byp_src2", add_src2, 32'h3F800000);
        send(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b010);
        wait_idle();
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        wait_idle();

        // Backpressure: queue fills, results drain in order
        res_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        send(32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_busy",     32'(busy),     32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data",  res_data,       32'h40400000);
        res_ready = 1'b1;
        wait_idle();

        // Asynchronous reset in EVAL with pairs still queued
        res_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        send(32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        res_ready = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        check("mid_rst_valid",    32'(res_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd1);
        check("mid_rst_busy",     32'(busy),      32'd0);
        check("mid_rst_src1",     add_src1,       32'd0);
        check("mid_rst_src2",     add_src2,       32'd0);
        check("mid_rst_data",     res_data,       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b1;

        // Denormal operands
`ifdef FPADD_FLUSH_DENORM_EN
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b001);
`else
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
`endif
        wait_idle();

        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        while (sb.size() != 0) begin
            void'(sb.pop_front());
            fail_timeout("result_missing");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
